// File: rtl/conv_pkg.sv
// Shared definitions for the single-PE convolution controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    // Array geometry and the shared mux select map: a00..a33 = 0..15,
    // b00..b22 = 16..24, constant zero = 25.
    localparam int          IN_DIM      = 4;
    localparam int          K_DIM       = 3;
    localparam logic [4:0]  INPUT_BASE  = 5'd0;
    localparam logic [4:0]  FILTER_BASE = 5'd16;
    localparam logic [4:0]  ZERO_SEL    = 5'd25;

    // Output pixel indices; bit 1 is the pixel row, bit 0 the column.
    localparam logic [1:0]  C11 = 2'd0;
    localparam logic [1:0]  C12 = 2'd1;
    localparam logic [1:0]  C21 = 2'd2;
    localparam logic [1:0]  C22 = 2'd3;

    localparam logic [3:0]  LAST_TAP  = 4'd8;
    localparam logic [1:0]  LAST_PIX  = 2'd3;
    localparam logic [1:0]  LAST_READ = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_WRITE,
        S_READ,
        S_RD_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Maps (output pixel, filter tap) to the input and filter mux selects.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//   pixel      : output pixel index, {row, col}
//   tap        : filter tap index 0..K_DIM*K_DIM-1, row-major
//   input_sel  : select of a[(row+i)][(col+j)]
//   filter_sel : select of b[i][j]
module conv_tap_addr_gen #(
    parameter int          IN_DIM      = 4,
    parameter int          K_DIM       = 3,
    parameter logic [4:0]  FILTER_BASE = 5'd16
) (
    input  logic [1:0] pixel,
    input  logic [3:0] tap,
    output logic [4:0] input_sel,
    output logic [4:0] filter_sel
);

    int tap_row;
    int tap_col;
    int in_row;
    int in_col;

    // Constant divisor, so this folds to a small lookup.
    always_comb begin
        tap_row    = int'(tap) / K_DIM;
        tap_col    = int'(tap) % K_DIM;
        in_row     = int'(pixel[1]) + tap_row;
        in_col     = int'(pixel[0]) + tap_col;
        input_sel  = 5'(in_row * IN_DIM + in_col);
        filter_sel = 5'(int'(FILTER_BASE) + tap_row * K_DIM + tap_col);
    end

endmodule

// File: rtl/convolution_single_controller.sv
// Sequencer for the single-PE 4x4 (*) 3x3 convolution: clear, 9 MACs, write per pixel, then stream 4 results.
// Latency: start sampled at edge E -> first pe_clr seen at E+1, done at E+50, busy E+1..E+50.
// Backpressure: none; start is ignored outside IDLE and the read stream runs unconditionally.
//   clk, rst                      : clock, synchronous active-high reset
//   start                         : begin one convolution (IDLE only)
//   input_array_addr_out          : input mux select (ZERO_SEL outside MAC)
//   filter_ceiling_array_addr_out : filter mux select (ZERO_SEL outside MAC)
//   sys_single_en, pe_clr         : PE MAC enable / accumulator clear
//   buffer_we_en_C11..C22         : one-cycle output buffer write strobes
//   buffer_read_addr_out          : output buffer read select
//   out_valid, busy, done         : read data valid, run in progress, completion pulse
module convolution_single_controller #(
    parameter int          IN_DIM      = 4,
    parameter int          K_DIM       = 3,
    parameter logic [4:0]  FILTER_BASE = 5'd16,
    parameter logic [4:0]  ZERO_SEL    = 5'd25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] input_array_addr_out,
    output logic [4:0] filter_ceiling_array_addr_out,
    output logic       sys_single_en,
    output logic       pe_clr,
    output logic       buffer_we_en_C11,
    output logic       buffer_we_en_C12,
    output logic       buffer_we_en_C21,
    output logic       buffer_we_en_C22,
    output logic [1:0] buffer_read_addr_out,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    import conv_pkg::*;

    state_t     state, state_n;
    logic [1:0] pix, pix_n;
    logic [3:0] tap, tap_n;
    logic [1:0] rd, rd_n;

    logic [4:0] gen_input_sel;
    logic [4:0] gen_filter_sel;

    logic [4:0] input_sel_n;
    logic [4:0] filter_sel_n;
    logic       en_n;
    logic       clr_n;
    logic [3:0] we_n;
    logic [1:0] read_addr_n;
    logic       out_valid_n;
    logic       busy_n;
    logic       done_n;

    // Fed with the next-cycle counters so the selects land in the output
    // registers in the same cycle the MAC state becomes visible.
    conv_tap_addr_gen #(
        .IN_DIM      (IN_DIM),
        .K_DIM       (K_DIM),
        .FILTER_BASE (FILTER_BASE)
    ) u_tap_addr_gen (
        .pixel      (pix_n),
        .tap        (tap_n),
        .input_sel  (gen_input_sel),
        .filter_sel (gen_filter_sel)
    );

    always_comb begin
        state_n = state;
        pix_n   = pix;
        tap_n   = tap;
        rd_n    = rd;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLEAR;
                    pix_n   = C11;
                end
            end
            S_CLEAR: begin
                state_n = S_MAC;
                tap_n   = 4'd0;
            end
            S_MAC: begin
                if (tap == LAST_TAP) begin
                    state_n = S_WRITE;
                end else begin
                    tap_n = tap + 4'd1;
                end
            end
            S_WRITE: begin
                if (pix != LAST_PIX) begin
                    pix_n   = pix + 2'd1;
                    state_n = S_CLEAR;
                end else begin
                    rd_n    = 2'd0;
                    state_n = S_READ;
                end
            end
            S_READ: begin
                if (rd == LAST_READ) begin
                    state_n = S_RD_WAIT;
                end else begin
                    rd_n = rd + 2'd1;
                end
            end
            S_RD_WAIT: state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Output values decoded from the next state and registered, so every
    // output is a clean flop that tracks the visible state.
    always_comb begin
        input_sel_n  = ZERO_SEL;
        filter_sel_n = ZERO_SEL;
        en_n         = 1'b0;
        clr_n        = 1'b0;
        we_n         = 4'b0000;
        read_addr_n  = 2'd0;
        done_n       = 1'b0;
        busy_n       = (state_n != S_IDLE);
        // The buffer returns data one cycle after the address, so valid
        // trails the READ state by one cycle (covering RD_WAIT).
        out_valid_n  = (state == S_READ);

        unique case (state_n)
            S_CLEAR: clr_n = 1'b1;
            S_MAC: begin
                en_n         = 1'b1;
                input_sel_n  = gen_input_sel;
                filter_sel_n = gen_filter_sel;
            end
            S_WRITE: we_n[pix_n] = 1'b1;
            S_READ:  read_addr_n = rd_n;
            S_DONE:  done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                         <= S_IDLE;
            pix                           <= 2'd0;
            tap                           <= 4'd0;
            rd                            <= 2'd0;
            input_array_addr_out          <= ZERO_SEL;
            filter_ceiling_array_addr_out <= ZERO_SEL;
            sys_single_en                 <= 1'b0;
            pe_clr                        <= 1'b0;
            buffer_we_en_C11              <= 1'b0;
            buffer_we_en_C12              <= 1'b0;
            buffer_we_en_C21              <= 1'b0;
            buffer_we_en_C22              <= 1'b0;
            buffer_read_addr_out          <= 2'd0;
            out_valid                     <= 1'b0;
            busy                          <= 1'b0;
            done                          <= 1'b0;
        end else begin
            state                         <= state_n;
            pix                           <= pix_n;
            tap                           <= tap_n;
            rd                            <= rd_n;
            input_array_addr_out          <= input_sel_n;
            filter_ceiling_array_addr_out <= filter_sel_n;
            sys_single_en                 <= en_n;
            pe_clr                        <= clr_n;
            buffer_we_en_C11              <= we_n[C11];
            buffer_we_en_C12              <= we_n[C12];
            buffer_we_en_C21              <= we_n[C21];
            buffer_we_en_C22              <= we_n[C22];
            buffer_read_addr_out          <= read_addr_n;
            out_valid                     <= out_valid_n;
            busy                          <= busy_n;
            done                          <= done_n;
        end
    end

endmodule

// File: tb/tb_convolution_single_controller.sv
// Bench for convolution_single_controller: cycle timeline plus end-to-end results through a datapath model.
// Latency: n/a.
// Backpressure: n/a.
module tb_convolution_single_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] input_array_addr_out;
    logic [4:0] filter_ceiling_array_addr_out;
    logic       sys_single_en;
    logic       pe_clr;
    logic       buffer_we_en_C11;
    logic       buffer_we_en_C12;
    logic       buffer_we_en_C21;
    logic       buffer_we_en_C22;
    logic [1:0] buffer_read_addr_out;
    logic       out_valid;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    convolution_single_controller dut (
        .clk                           (clk),
        .rst                           (rst),
        .start                         (start),
        .input_array_addr_out          (input_array_addr_out),
        .filter_ceiling_array_addr_out (filter_ceiling_array_addr_out),
        .sys_single_en                 (sys_single_en),
        .pe_clr                        (pe_clr),
        .buffer_we_en_C11              (buffer_we_en_C11),
        .buffer_we_en_C12              (buffer_we_en_C12),
        .buffer_we_en_C21              (buffer_we_en_C21),
        .buffer_we_en_C22              (buffer_we_en_C22),
        .buffer_read_addr_out          (buffer_read_addr_out),
        .out_valid                     (out_valid),
        .busy                          (busy),
        .done                          (done)
    );

    // All controller outputs packed for one comparison per cycle:
    // {in_sel, filt_sel, en, clr, we_C22, we_C21, we_C12, we_C11, raddr, valid, busy, done}
    logic [20:0] obs;
    assign obs = {input_array_addr_out, filter_ceiling_array_addr_out, sys_single_en, pe_clr,
                  buffer_we_en_C22, buffer_we_en_C21, buffer_we_en_C12, buffer_we_en_C11,
                  buffer_read_addr_out, out_valid, busy, done};

    // Datapath stand-in: 26-way operand mux, one MAC PE, four result
    // registers and a registered read port.
    int unsigned a_mem [16];
    int unsigned b_mem [9];
    logic [31:0] acc;
    logic [31:0] res_mem [4];
    logic [31:0] rd_data;

    function automatic logic [31:0] mux_val(input logic [4:0] sel);
        if (sel < 5'd16) return a_mem[sel];
        if (sel < 5'd25) return b_mem[int'(sel) - 16];
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (rst || pe_clr) acc <= 32'd0;
        else if (sys_single_en)
            acc <= acc + mux_val(input_array_addr_out) * mux_val(filter_ceiling_array_addr_out);
        if (buffer_we_en_C11) res_mem[0] <= acc;
        if (buffer_we_en_C12) res_mem[1] <= acc;
        if (buffer_we_en_C21) res_mem[2] <= acc;
        if (buffer_we_en_C22) res_mem[3] <= acc;
        rd_data <= res_mem[buffer_read_addr_out];
    end

    // Plain 2-D valid convolution (correlation form) of the current operands.
    function automatic logic [31:0] conv_ref(input int pixel);
        int pr, pc;
        logic [31:0] s;
        pr = pixel / 2;
        pc = pixel % 2;
        s  = 32'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += a_mem[(pr + i) * 4 + (pc + j)] * b_mem[i * 3 + j];
        return s;
    endfunction

    // Expected outputs n cycles after the accepted start edge: four
    // 11-cycle pixel slots (clear, 9 taps, write), 4 read addresses,
    // valid trailing by one, done at 50. n outside 1..50 is the idle/reset value.
    function automatic logic [20:0] exp_obs(input int n);
        logic [4:0] is_, fs_;
        logic       en_, clr_, ov_, bz_, dn_;
        logic [3:0] we_;
        logic [1:0] ra_;
        int pix, off, k;
        is_ = 5'd25; fs_ = 5'd25; en_ = 1'b0; clr_ = 1'b0; we_ = 4'b0;
        ra_ = 2'd0; ov_ = 1'b0; bz_ = 1'b0; dn_ = 1'b0;
        if (n >= 1 && n <= 50) bz_ = 1'b1;
        if (n >= 1 && n <= 44) begin
            pix = (n - 1) / 11;
            off = (n - 1) % 11;
            if (off == 0) clr_ = 1'b1;
            else if (off <= 9) begin
                k   = off - 1;
                en_ = 1'b1;
                is_ = 5'(((pix / 2) + k / 3) * 4 + (pix % 2) + k % 3);
                fs_ = 5'(16 + k);
            end else we_[pix] = 1'b1;
        end
        if (n >= 45 && n <= 48) ra_ = 2'(n - 45);
        if (n >= 46 && n <= 49) ov_ = 1'b1;
        if (n == 50) dn_ = 1'b1;
        return {is_, fs_, en_, clr_, we_, ra_, ov_, bz_, dn_};
    endfunction

    int pass_cnt = 0;
    int total    = 0;

    logic [20:0] obs_log [0:127];
    logic [31:0] words [$];

    // Pulses start for edge E, records outputs before each edge E+n, and
    // raises start again before the edges listed in s1..s3.
    task automatic do_run(input int ncyc, input int s1, input int s2, input int s3);
        words.delete();
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            obs_log[n] = obs;
            if (out_valid) words.push_back(rd_data);
            start = (n == s1) || (n == s2) || (n == s3);
        end
        start = 1'b0;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < 16; i++) a_mem[i] = $urandom_range(0, 255);
        for (int i = 0; i < 9; i++)  b_mem[i] = $urandom_range(0, 255);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== exp_obs(0))
            $display("FAIL reset_state got %h expected %h", obs, exp_obs(0));
        else pass_cnt++;
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_conv_patterns();
        for (int pat = 0; pat < 4; pat++) begin
            if (pat == 0) begin
                for (int i = 0; i < 16; i++) a_mem[i] = 1;
                for (int i = 0; i < 9; i++)  b_mem[i] = 1;
            end else if (pat == 1) begin
                for (int i = 0; i < 16; i++) a_mem[i] = i;
                for (int i = 0; i < 9; i++)  b_mem[i] = (i == 4) ? 1 : 0;
            end else randomize_operands();
            do_run(52, -1, -1, -1);
            for (int n = 1; n <= 52; n++) begin
                total++;
                if (obs_log[n] !== exp_obs(n))
                    $display("FAIL pattern%0d_cycle E+%0d got %h expected %h",
                             pat, n, obs_log[n], exp_obs(n));
                else pass_cnt++;
            end
            total++;
            if (words.size() != 4)
                $display("FAIL pattern%0d_word_count got %0d expected 4", pat, words.size());
            else begin
                pass_cnt++;
                for (int w = 0; w < 4; w++) begin
                    total++;
                    if (words[w] !== conv_ref(w))
                        $display("FAIL pattern%0d_word%0d got %0d expected %0d",
                                 pat, w, words[w], conv_ref(w));
                    else pass_cnt++;
                end
            end
        end
    endtask

    // Starts at E+20 (mid-run) and E+50 (DONE) must be ignored; the start
    // held into E+51 (IDLE) launches a second run.
    task automatic test_start_ignored();
        logic [20:0] e;
        randomize_operands();
        do_run(104, 20, 50, 51);
        for (int n = 1; n <= 104; n++) begin
            if (n <= 50)       e = exp_obs(n);
            else if (n == 51)  e = exp_obs(0);
            else               e = exp_obs(n - 51);
            total++;
            if (obs_log[n] !== e)
                $display("FAIL restart_cycle E+%0d got %h expected %h", n, obs_log[n], e);
            else pass_cnt++;
        end
        total++;
        if (words.size() != 8)
            $display("FAIL restart_word_count got %0d expected 8", words.size());
        else begin
            pass_cnt++;
            for (int w = 0; w < 8; w++) begin
                total++;
                if (words[w] !== conv_ref(w % 4))
                    $display("FAIL restart_word%0d got %0d expected %0d",
                             w, words[w], conv_ref(w % 4));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_run();
        randomize_operands();
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if (obs !== exp_obs(n))
                $display("FAIL midreset_pre E+%0d got %h expected %h", n, obs, exp_obs(n));
            else pass_cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== exp_obs(0))
            $display("FAIL midreset_after got %h expected %h", obs, exp_obs(0));
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        randomize_operands();
        do_run(52, -1, -1, -1);
        for (int n = 1; n <= 52; n++) begin
            total++;
            if (obs_log[n] !== exp_obs(n))
                $display("FAIL midreset_rerun E+%0d got %h expected %h",
                         n, obs_log[n], exp_obs(n));
            else pass_cnt++;
        end
        total++;
        if (words.size() != 4)
            $display("FAIL midreset_word_count got %0d expected 4", words.size());
        else begin
            pass_cnt++;
            for (int w = 0; w < 4; w++) begin
                total++;
                if (words[w] !== conv_ref(w))
                    $display("FAIL midreset_word%0d got %0d expected %0d",
                             w, words[w], conv_ref(w));
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_conv_patterns();
        test_start_ignored();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
